// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: PC control, instruction memory port,
// decode handshake, execute redirect and status.
interface fetch_sequencer_if #(
    parameter int unsigned size = 16
);
    logic            start;
    logic [size-1:0] pc;
    logic [size-1:0] pc_in;
    logic            load_pc;
    logic            incr_pc;
    logic [size-1:0] mem_addr;
    logic            mem_rd;
    logic [size-1:0] mem_rdata;
    logic            mem_ack;
    logic [size-1:0] ir;
    logic [size-1:0] ir_pc;
    logic            ir_valid;
    logic            ir_ready;
    logic            redirect;
    logic [size-1:0] redirect_addr;
    logic            halted;

    // Sequencer side
    modport master (
        input  start, pc, mem_rdata, mem_ack, ir_ready, redirect, redirect_addr,
        output pc_in, load_pc, incr_pc, mem_addr, mem_rd, ir, ir_pc, ir_valid, halted
    );

    // Environment side (PC, memory, decode, execute)
    modport slave (
        output start, pc, mem_rdata, mem_ack, ir_ready, redirect, redirect_addr,
        input  pc_in, load_pc, incr_pc, mem_addr, mem_rd, ir, ir_pc, ir_valid, halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: fetches at pc, resolves JMP/HALT locally,
// hands other instructions to decode, and obeys execute-stage redirects.
module fetch_sequencer #(
    parameter int unsigned size = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    fetch_sequencer_if.master  bus
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned OP_LSB = size - OP_W;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hF;
    localparam logic [OP_W-1:0] OP_HALT = 4'hE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_abort;
    logic [size-1:0] r_ir;
    logic [size-1:0] r_ir_pc;
    logic            r_ir_valid;
    logic            r_halted;

    logic [OP_W-1:0] w_op;
    logic [size-1:0] w_jmp_target;
    logic            w_req;
    logic            w_ack;
    logic            w_load;
    logic            w_incr;
    logic [size-1:0] w_pc_in;

    // Mealy decode of the PC strobes and memory request
    always_comb begin
        w_op         = bus.mem_rdata[size-1 -: OP_W];
        w_jmp_target = {bus.pc[size-1 -: OP_W], bus.mem_rdata[OP_LSB-1:0]};
        // The cycle after an aborted request is a bubble with no request out
        w_req        = (r_state == S_FETCH) && !r_abort;
        w_ack        = w_req && bus.mem_ack && !bus.redirect;
        w_load       = 1'b0;
        w_incr       = 1'b0;
        if (reset_n) begin
            if (bus.redirect) begin
                w_load = 1'b1;
            end else if (w_ack) begin
                if (w_op == OP_JMP) begin
                    w_load = 1'b1;
                end else begin
                    w_incr = 1'b1;
                end
            end
        end
        w_pc_in = bus.redirect ? bus.redirect_addr : w_jmp_target;
    end

    // Sequencing state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_abort    <= 1'b0;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.redirect && bus.start) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.redirect) begin
                        r_abort <= 1'b1;
                    end else if (w_ack) begin
                        if (w_op == OP_HALT) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else if (w_op != OP_JMP) begin
                            r_ir       <= bus.mem_rdata;
                            r_ir_pc    <= bus.pc;
                            r_ir_valid <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.redirect || bus.ir_ready) begin
                        r_ir_valid <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (!bus.redirect && bus.start) begin
                        r_halted <= 1'b0;
                        r_state  <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pc_in    = w_pc_in;
    assign bus.load_pc  = w_load;
    assign bus.incr_pc  = w_incr;
    assign bus.mem_addr = bus.pc;
    assign bus.mem_rd   = w_req;
    assign bus.ir       = r_ir;
    assign bus.ir_pc    = r_ir_pc;
    assign bus.ir_valid = r_ir_valid;
    assign bus.halted   = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written reset and
// backpressure sequences, then random traffic against a program-walk model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    int          total = 0;
    int          bad   = 0;

    fetch_sequencer_if #(.size(16)) bus ();

    fetch_sequencer #(.size(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        ack;
        logic [15:0] rdata;
        logic        ready;
        logic        redir;
        logic [15:0] raddr;
        logic        e_rd;
        logic        e_ld;
        logic        e_inc;
        logic [15:0] e_pcin;
        logic        e_irv;
        logic [15:0] e_ir;
        logic [15:0] e_irpc;
        logic        e_halt;
        logic [15:0] e_addr;
    } vec_t;

    vec_t        tbl [21];
    logic [15:0] mem [4096];

    function automatic vec_t mkv(int st, int ak, int rd, int rdy, int rdr, int ra,
                                 int erd, int eld, int einc, int epc, int eirv,
                                 int eir, int eirpc, int eh, int ea);
        vec_t v;
        v.start  = 1'(st);   v.ack    = 1'(ak);    v.rdata  = 16'(rd);
        v.ready  = 1'(rdy);  v.redir  = 1'(rdr);   v.raddr  = 16'(ra);
        v.e_rd   = 1'(erd);  v.e_ld   = 1'(eld);   v.e_inc  = 1'(einc);
        v.e_pcin = 16'(epc); v.e_irv  = 1'(eirv);  v.e_ir   = 16'(eir);
        v.e_irpc = 16'(eirpc); v.e_halt = 1'(eh);  v.e_addr = 16'(ea);
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic ak, input logic [15:0] rd,
                         input logic rdy, input logic rdr, input logic [15:0] ra);
        bus.start         = st;
        bus.mem_ack       = ak;
        bus.mem_rdata     = rd;
        bus.ir_ready      = rdy;
        bus.redirect      = rdr;
        bus.redirect_addr = ra;
    endtask

    // Advance one clock; the program counter follows the strobes seen before the edge
    task automatic tick();
        logic        lp;
        logic        ip;
        logic [15:0] pin;
        lp  = bus.load_pc;
        ip  = bus.incr_pc;
        pin = bus.pc_in;
        @(posedge clk);
        #1;
        if (lp)      pc = pin;
        else if (ip) pc = pc + 16'd1;
        bus.pc = pc;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk16({tag, "_ir"},    bus.ir,       16'h0000);
        chk16({tag, "_ir_pc"}, bus.ir_pc,    16'h0000);
        chk1 ({tag, "_irv"},   bus.ir_valid, 1'b0);
        chk1 ({tag, "_halt"},  bus.halted,   1'b0);
        chk1 ({tag, "_rd"},    bus.mem_rd,   1'b0);
        chk1 ({tag, "_load"},  bus.load_pc,  1'b0);
        chk1 ({tag, "_incr"},  bus.incr_pc,  1'b0);
    endtask

    initial begin
        int          incr_cnt;
        int          wcnt;
        int          hs_cnt;
        logic [15:0] wa;
        logic [15:0] w;
        logic [15:0] rd;
        logic [15:0] ra;
        logic        ak;
        logic        rdy;
        logic        rdr;
        logic        hold;
        logic [15:0] prev_ir;
        logic [15:0] prev_irpc;

        //         st ak rdata   rdy rdr raddr    rd ld in pc_in   irv ir      ir_pc   h  addr
        tbl[0]  = mkv(1, 0, 'h0000, 0, 0, 'h0000,  0, 0, 0, 'h0000, 0, 'h0000, 'h0000, 0, 'h0000);
        tbl[1]  = mkv(0, 1, 'h1234, 1, 0, 'h0000,  1, 0, 1, 'h0000, 0, 'h0000, 'h0000, 0, 'h0000);
        tbl[2]  = mkv(0, 0, 'h0000, 1, 0, 'h0000,  0, 0, 0, 'h0000, 1, 'h1234, 'h0000, 0, 'h0001);
        tbl[3]  = mkv(0, 1, 'h2345, 1, 0, 'h0000,  1, 0, 1, 'h0000, 0, 'h1234, 'h0000, 0, 'h0001);
        tbl[4]  = mkv(0, 0, 'h0000, 1, 0, 'h0000,  0, 0, 0, 'h0000, 1, 'h2345, 'h0001, 0, 'h0002);
        tbl[5]  = mkv(0, 0, 'h0000, 0, 1, 'h3010,  1, 1, 0, 'h3010, 0, 'h2345, 'h0001, 0, 'h0002);
        tbl[6]  = mkv(0, 0, 'h0000, 0, 0, 'h0000,  0, 0, 0, 'h0000, 0, 'h2345, 'h0001, 0, 'h3010);
        tbl[7]  = mkv(0, 1, 'hF0AB, 0, 0, 'h0000,  1, 1, 0, 'h30AB, 0, 'h2345, 'h0001, 0, 'h3010);
        tbl[8]  = mkv(0, 0, 'h0000, 0, 0, 'h0000,  1, 0, 0, 'h0000, 0, 'h2345, 'h0001, 0, 'h30AB);
        tbl[9]  = mkv(0, 1, 'h1111, 1, 1, 'h0005,  1, 1, 0, 'h0005, 0, 'h2345, 'h0001, 0, 'h30AB);
        tbl[10] = mkv(0, 0, 'h0000, 0, 0, 'h0000,  0, 0, 0, 'h0000, 0, 'h2345, 'h0001, 0, 'h0005);
        tbl[11] = mkv(0, 1, 'hE000, 0, 0, 'h0000,  1, 0, 1, 'h0000, 0, 'h2345, 'h0001, 0, 'h0005);
        tbl[12] = mkv(0, 0, 'h0000, 0, 0, 'h0000,  0, 0, 0, 'h0000, 0, 'h2345, 'h0001, 1, 'h0006);
        tbl[13] = mkv(0, 0, 'h0000, 0, 0, 'h0000,  0, 0, 0, 'h0000, 0, 'h2345, 'h0001, 1, 'h0006);
        tbl[14] = mkv(1, 0, 'h0000, 0, 0, 'h0000,  0, 0, 0, 'h0000, 0, 'h2345, 'h0001, 1, 'h0006);
        tbl[15] = mkv(0, 1, 'h4444, 0, 0, 'h0000,  1, 0, 1, 'h0000, 0, 'h2345, 'h0001, 0, 'h0006);
        tbl[16] = mkv(0, 0, 'h0000, 0, 0, 'h0000,  0, 0, 0, 'h0000, 1, 'h4444, 'h0006, 0, 'h0007);
        tbl[17] = mkv(0, 0, 'h0000, 1, 1, 'h0200,  0, 1, 0, 'h0200, 1, 'h4444, 'h0006, 0, 'h0007);
        tbl[18] = mkv(0, 1, 'h5555, 1, 0, 'h0000,  1, 0, 1, 'h0000, 0, 'h4444, 'h0006, 0, 'h0200);
        tbl[19] = mkv(0, 0, 'h0000, 1, 0, 'h0000,  0, 0, 0, 'h0000, 1, 'h5555, 'h0200, 0, 'h0201);
        tbl[20] = mkv(0, 0, 'h0000, 0, 0, 'h0000,  1, 0, 0, 'h0000, 0, 'h5555, 'h0200, 0, 'h0201);

        // Reset with start and redirect active: strobes must stay low
        reset_n = 1'b0;
        pc      = 16'h0000;
        bus.pc  = pc;
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1234);
        #1;
        chk_reset_vals("rst");
        tick();
        tick();
        reset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].start, tbl[i].ack, tbl[i].rdata, tbl[i].ready, tbl[i].redir, tbl[i].raddr);
            #1;
            chk1 ($sformatf("r%0d_mem_rd", i),  bus.mem_rd,   tbl[i].e_rd);
            chk1 ($sformatf("r%0d_load", i),    bus.load_pc,  tbl[i].e_ld);
            chk1 ($sformatf("r%0d_incr", i),    bus.incr_pc,  tbl[i].e_inc);
            if (tbl[i].e_ld)
                chk16($sformatf("r%0d_pc_in", i), bus.pc_in,  tbl[i].e_pcin);
            chk1 ($sformatf("r%0d_irv", i),     bus.ir_valid, tbl[i].e_irv);
            chk16($sformatf("r%0d_ir", i),      bus.ir,       tbl[i].e_ir);
            chk16($sformatf("r%0d_ir_pc", i),   bus.ir_pc,    tbl[i].e_irpc);
            chk1 ($sformatf("r%0d_halted", i),  bus.halted,   tbl[i].e_halt);
            chk16($sformatf("r%0d_mem_addr", i), bus.mem_addr, tbl[i].e_addr);
            tick();
        end

        // Async reset while a request is outstanding
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        #1;
        chk1("pre_rst_fetch_rd", bus.mem_rd, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_fetch");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1($sformatf("idle_after_rst%0d_rd", i), bus.mem_rd, 1'b0);
            tick();
        end

        // Wait states and decode backpressure, starting at 0x0040
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0040);
        #1;
        chk1 ("bp_idle_redir_load", bus.load_pc, 1'b1);
        chk16("bp_idle_redir_pcin", bus.pc_in,   16'h0040);
        tick();
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        #1;
        chk1("bp_start_rd", bus.mem_rd, 1'b0);
        tick();
        incr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'(i == 3), 16'h7777, 1'b0, 1'b0, 16'h0);
            #1;
            chk1 ($sformatf("bp_wait%0d_rd", i),   bus.mem_rd,   1'b1);
            chk16($sformatf("bp_wait%0d_addr", i), bus.mem_addr, 16'h0040);
            if (bus.incr_pc) incr_cnt++;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 16'h0, 1'(i == 4), 1'b0, 16'h0);
            #1;
            chk1 ($sformatf("bp_hold%0d_irv", i),  bus.ir_valid, 1'b1);
            chk16($sformatf("bp_hold%0d_ir", i),   bus.ir,       16'h7777);
            chk16($sformatf("bp_hold%0d_irpc", i), bus.ir_pc,    16'h0040);
            chk1 ($sformatf("bp_hold%0d_rd", i),   bus.mem_rd,   1'b0);
            if (bus.incr_pc) incr_cnt++;
            tick();
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        #1;
        chk1 ("bp_after_irv",  bus.ir_valid, 1'b0);
        chk1 ("bp_after_rd",   bus.mem_rd,   1'b1);
        chk16("bp_after_addr", bus.mem_addr, 16'h0041);
        if (bus.incr_pc) incr_cnt++;
        chk16("bp_incr_count", 16'(incr_cnt), 16'd1);

        // Async reset while an instruction is offered to decode
        drive(1'b0, 1'b1, 16'h1357, 1'b0, 1'b0, 16'h0);
        #1;
        chk1("mi_ack_incr", bus.incr_pc, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0BAD);
        #1;
        chk1 ("mi_pre_irv", bus.ir_valid, 1'b1);
        chk16("mi_pre_ir",  bus.ir,       16'h1357);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_issue");
        tick();
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk1($sformatf("mi_idle%0d_rd", i),  bus.mem_rd,   1'b0);
            chk1($sformatf("mi_idle%0d_irv", i), bus.ir_valid, 1'b0);
            tick();
        end

        // Random program: normal opcodes and short forward jumps, no HALT
        for (int i = 0; i < 4096; i++) begin
            if ($urandom_range(0, 9) < 2 && i + 8 < 4096)
                mem[i] = {4'hF, 12'(i + int'($urandom_range(1, 8)))};
            else
                mem[i] = {4'($urandom_range(0, 13)), 12'($urandom)};
        end
        wa        = pc;
        wcnt      = int'($urandom_range(0, 3));
        hs_cnt    = 0;
        hold      = 1'b0;
        prev_ir   = 16'h0;
        prev_irpc = 16'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdr = ($urandom_range(0, 19) == 0);
            ra  = 16'($urandom_range(0, 16'h07FF));
            rdy = 1'($urandom_range(0, 1));
            ak  = 1'b0;
            if (bus.mem_rd) begin
                if (wcnt == 0) begin
                    ak   = 1'b1;
                    wcnt = int'($urandom_range(0, 3));
                end else begin
                    wcnt--;
                end
            end
            rd = ak ? mem[pc[11:0]] : 16'($urandom);
            drive(1'b1, ak, rd, rdy, rdr, ra);
            #1;
            chk16("rnd_mem_addr", bus.mem_addr, pc);
            chk1 ("rnd_halted",   bus.halted,   1'b0);
            if (hold) begin
                chk1 ("rnd_hold_irv",  bus.ir_valid, 1'b1);
                chk16("rnd_hold_ir",   bus.ir,       prev_ir);
                chk16("rnd_hold_irpc", bus.ir_pc,    prev_irpc);
            end
            if (rdr) begin
                chk1 ("rnd_redir_load", bus.load_pc, 1'b1);
                chk1 ("rnd_redir_incr", bus.incr_pc, 1'b0);
                chk16("rnd_redir_pcin", bus.pc_in,   ra);
            end else if (bus.mem_rd && ak) begin
                if (rd[15:12] == 4'hF) begin
                    chk1 ("rnd_jmp_load", bus.load_pc, 1'b1);
                    chk1 ("rnd_jmp_incr", bus.incr_pc, 1'b0);
                    chk16("rnd_jmp_pcin", bus.pc_in,   {pc[15:12], rd[11:0]});
                end else begin
                    chk1("rnd_norm_load", bus.load_pc, 1'b0);
                    chk1("rnd_norm_incr", bus.incr_pc, 1'b1);
                end
            end else begin
                chk1("rnd_quiet_load", bus.load_pc, 1'b0);
                chk1("rnd_quiet_incr", bus.incr_pc, 1'b0);
            end
            // Accepted instruction must be the next non-jump word on the program walk
            if (!rdr && bus.ir_valid && rdy) begin
                for (int s = 0; s < 64; s++) begin
                    w = mem[wa[11:0]];
                    if (w[15:12] == 4'hF) wa = {wa[15:12], w[11:0]};
                    else break;
                end
                chk16("rnd_ir",    bus.ir,    mem[wa[11:0]]);
                chk16("rnd_ir_pc", bus.ir_pc, wa);
                wa = wa + 16'd1;
                hs_cnt++;
            end
            if (rdr) wa = ra;
            hold      = bus.ir_valid && !rdy && !rdr;
            prev_ir   = bus.ir;
            prev_irpc = bus.ir_pc;
            tick();
        end
        total++;
        if (hs_cnt < 100) begin
            bad++;
            $display("FAIL rnd_handshakes: got %0d want >= 100", hs_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
